// File: rtl/key_bounce_gen.sv
// Mechanical-key emulator: press bounce, clean hold, release bounce on key_out (active-low); KEY_BOUNCE_EN enables LFSR bounce toggling.
// Event spans 2*BOUNCE_CYC+HOLD_CYC cycles after press_req; done pulses next cycle; requests while busy or in the done cycle are dropped.
module key_bounce_gen #(
  parameter logic [23:0] BOUNCE_CYC = 24'd250_000,
  parameter logic [23:0] HOLD_CYC   = 24'd2_500_000,
  parameter int          SEG_W      = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       press_req,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] edge_cnt
);

  typedef enum logic [1:0] {IDLE, P_BNC, HOLD, R_BNC} state_t;

  state_t      state_q, state_d;
  logic [23:0] wcnt_q, wcnt_d;
  logic        key_q, key_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic [7:0]  edge_cnt_q, edge_cnt_d;
  logic [7:0]  ecnt_base;
  logic        start;
  logic        win_end;
  logic        tgl;

  // The done cycle is already IDLE, so it has to be excluded explicitly.
  assign start   = (state_q == IDLE) && !done_q && press_req;
  assign win_end = (wcnt_q == 24'd0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = P_BNC;
      P_BNC:   if (win_end) state_d = HOLD;
      HOLD:    if (win_end) state_d = R_BNC;
      R_BNC:   if (win_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d != state_q) begin
      case (state_d)
        P_BNC, R_BNC: wcnt_d = BOUNCE_CYC - 24'd1;
        HOLD:         wcnt_d = HOLD_CYC - 24'd1;
        default:      wcnt_d = 24'd0;
      endcase
    end else if (!win_end) begin
      wcnt_d = wcnt_q - 24'd1;
    end
  end

`ifdef KEY_BOUNCE_EN
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0]      lfsr_q, lfsr_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             in_bnc;
  logic             bnc_entry;

  assign in_bnc    = (state_q == P_BNC) || (state_q == R_BNC);
  assign bnc_entry = (state_d != state_q) && ((state_d == P_BNC) || (state_d == R_BNC));
  assign tgl       = in_bnc && (seg_q == '0);

  // LFSR is frozen in IDLE so each event replays deterministically from where the last one stopped.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q != IDLE) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    seg_d = seg_q;
    if (bnc_entry || tgl) begin
      seg_d = lfsr_q[SEG_W-1:0];
    end else if (seg_q != '0) begin
      seg_d = seg_q - SEG_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lfsr_q <= SEED_EFF;
      seg_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      seg_q  <= seg_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, SEG_W[0]};
  assign tgl        = 1'b0;
`endif

  // Window entry and the cycle after wcnt==1 (the window's last cycle) pin the level.
  always_comb begin
    key_d  = key_q;
    busy_d = (state_d != IDLE);
    done_d = (state_q == R_BNC) && win_end;
    case (state_d)
      IDLE:    key_d = 1'b1;
      P_BNC:   key_d = ((state_q != P_BNC) || (wcnt_q == 24'd1)) ? 1'b0 : (key_q ^ tgl);
      HOLD:    key_d = 1'b0;
      R_BNC:   key_d = ((state_q != R_BNC) || (wcnt_q == 24'd1)) ? 1'b1 : (key_q ^ tgl);
      default: key_d = 1'b1;
    endcase
  end

  always_comb begin
    ecnt_base = start ? 8'd0 : ecnt_q;
    ecnt_d    = ecnt_base;
    if ((key_d != key_q) && (ecnt_base != 8'hFF)) begin
      ecnt_d = ecnt_base + 8'd1;
    end
    edge_cnt_d = done_d ? ecnt_q : edge_cnt_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wcnt_q     <= 24'd0;
      key_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ecnt_q     <= 8'd0;
      edge_cnt_q <= 8'd0;
    end else begin
      wcnt_q     <= wcnt_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ecnt_q     <= ecnt_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign key_out  = key_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign edge_cnt = edge_cnt_q;

endmodule

// File: doc/key_bounce_gen.md
Name: key_bounce_gen

Overview:
- Stimulus-side counterpart of the key debounce filter.
- On a one-cycle request, drives an active-low mechanical-key waveform on key_out: a pseudo-random bounce burst on press, a clean low hold, then a bounce burst on release.
- Used as an on-chip key emulator feeding debounce/PWM-control logic, and as a self-test source for the filter.

Parameters:
- BOUNCE_CYC, 24'd250_000, length in cycles of each bounce window (5 ms at 50 MHz); must be ≥2.
- HOLD_CYC, 24'd2_500_000, cycles key_out is held steady low between windows (50 ms); must be ≥1.
- SEG_W, 8, width of the LFSR field that sets bounce segment length (1..2^SEG_W cycles).
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- sys_clk  input  1  system clock, 50 MHz
- sys_rst  input  1  reset, asynchronous, active-high
- press_req  input  1  one-cycle start pulse; honoured only in IDLE
- key_out  output  1  emulated key line, active-low (1 = released)
- busy  output  1  high while an event is in progress
- done  output  1  one-cycle pulse when an event completes
- edge_cnt  output  8  key_out transitions in the last completed event, saturating at 255

Behaviour:
- Reset values: key_out=1, busy=0, done=0, edge_cnt=0, lfsr=seed, state=IDLE. All outputs are registered.
- FSM states: IDLE → P_BNC → HOLD → R_BNC → IDLE.
- Timeline, with press_req sampled high in IDLE at cycle N; B=BOUNCE_CYC, H=HOLD_CYC:
  - P_BNC occupies cycles N+1..N+B.
    - key_out=0 at N+1.
    - key_out toggles each time seg_cnt expires.
    - key_out is forced 0 in cycle N+B regardless of toggle.
  - HOLD occupies cycles N+B+1..N+B+H; key_out=0 steady.
  - R_BNC occupies cycles N+B+H+1..N+2B+H.
    - key_out=1 at first cycle.
    - key_out toggles on segment expiry.
    - key_out is forced 1 in the last cycle.
  - busy=1 during cycles N+1..N+2B+H.
  - At cycle N+2B+H+1: state=IDLE, busy=0, done=1 for exactly that cycle, edge_cnt updated.
- Window counter: a 24-bit down counter, loaded with B-1 or H-1 on state entry; the state changes when it reaches 0.
- Segment counter (SEG_W bits):
  - Loaded with lfsr[SEG_W-1:0] on bounce-window entry and after each toggle.
  - When it reaches 0, key_out toggles and it reloads.
  - A toggle falling in the forced last cycle is suppressed.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts once per cycle while busy; frozen in IDLE, so the sequence is deterministic per event.
- Edge counting:
  - An internal counter clears on event start and increments on every key_out change, including the initial fall and final rise.
  - Saturates at 255; copied to edge_cnt when done fires.
  - Minimum possible value is 2.
- press_req while busy, or in the done cycle itself, is ignored and not queued.
- press_req asserted for multiple cycles starts exactly one event; the next event requires press_req high in a later IDLE cycle.
- Reset asserted mid-event: key_out returns to 1 asynchronously, the event is abandoned, no done pulse, edge_cnt=0.

Optional Feature:
- Macro: KEY_BOUNCE_EN.
- Defined: bounce toggling as described.
- Undefined:
  - Segment counter and LFSR are not built; key_out holds 0 for all of P_BNC and HOLD and 1 for all of R_BNC.
  - State timing, busy and done are identical to the defined case; edge_cnt is always 2.

Test Plan (BOUNCE_CYC=16, HOLD_CYC=32, SEG_W=3, LFSR_SEED=16'hACE1 unless stated):
- Single event, macro defined:
  - Stimulus: press_req pulse at cycle N.
  - Response: busy high for N+1..N+64; key_out=0 at N+1, N+16, and throughout N+17..N+48; key_out=1 at N+49 and N+64 onward; done=1 only at N+65.
  - edge_cnt equals the bench-model count of key_out transitions (≥2); the model replays the LFSR.
- Clean mode, macro undefined, same stimulus:
  - key_out=0 for N+1..N+48 and 1 from N+49; edge_cnt=2; done at N+65.
- Request while busy:
  - Pulse press_req at N, N+10, and N+65 (the done cycle).
  - Response: one event only; busy falls after N+64 and stays low.
- Back-to-back events: pulse at N, then at N+66.
  - The second event starts at N+67; its key_out pattern differs from the first (LFSR continued, not reseeded).
- Reset mid-HOLD: assert sys_rst at N+30 for 2 cycles.
  - Response: key_out=1 and busy=0 immediately; no done pulse; edge_cnt=0.
  - A subsequent request reproduces the first event's pattern exactly (LFSR reseeded).
- Zero seed: LFSR_SEED=0.
  - Response: the LFSR runs from 16'h0001; key_out still shows ≥1 bounce toggle per window over a 2-event run.
